// File: rtl/irq_controller.sv
// Three-line prioritised interrupt controller: synchronises and edge-detects raw lines,
// latches pending bits and hands one request at a time to the CPU (IDLE -> REQ -> SERVICE).
module irq_controller #(
    parameter logic [3:0] VEC_BASE   = 4'h4,
    parameter logic [3:0] VEC_STRIDE = 4'h1
) (
    input  logic       CLOCK_50,
    input  logic       KEY,
    input  logic [2:0] INT_IN,
    input  logic [2:0] INT_MASK,
    input  logic       IRQ_ACK,
    input  logic       IRQ_DONE,
    output logic       IRQ_REQ,
    output logic [1:0] IRQ_NUM,
    output logic [3:0] IRQ_ADDR,
    output logic [2:0] IRQ_PENDING,
    output logic       IRQ_ACTIVE
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

    state_e     state_q, state_d;
    logic [1:0] num_q, num_d;
    logic [2:0] sync1_q, sync2_q, prev_q;
    logic [1:0] warm_q;
    logic [2:0] pend_q, pend_d;
    logic [2:0] rise, clr, enabled;

    // Edge detection is held off until the previous-sample flop carries a real sample,
    // so a line already high when reset releases is not mistaken for a new edge.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
            warm_q  <= 2'd0;
        end else begin
            sync1_q <= INT_IN;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    assign rise    = (warm_q == 2'd3) ? (sync2_q & ~prev_q) : 3'b000;
    assign pend_d  = (pend_q & ~clr) | rise;
    assign enabled = pend_q & INT_MASK;

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            pend_q <= 3'b000;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q <= IDLE;
            num_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        clr     = 3'b000;
        case (state_q)
            IDLE: begin
                if (enabled != 3'b000) begin
                    state_d = REQ;
                    if (enabled[0]) begin
                        num_d = 2'd1;
                    end else if (enabled[1]) begin
                        num_d = 2'd2;
                    end else begin
                        num_d = 2'd3;
                    end
                end
            end
            REQ: begin
                if (IRQ_ACK) begin
                    state_d = SERVICE;
                    case (num_q)
                        2'd1:    clr = 3'b001;
                        2'd2:    clr = 3'b010;
                        2'd3:    clr = 3'b100;
                        default: clr = 3'b000;
                    endcase
                end
            end
            SERVICE: begin
                if (IRQ_DONE) begin
                    state_d = IDLE;
                    num_d   = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                num_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        IRQ_REQ     = (state_q == REQ);
        IRQ_ACTIVE  = (state_q == SERVICE);
        IRQ_NUM     = num_q;
        IRQ_PENDING = pend_q;
        IRQ_ADDR    = 4'h0;
        if (num_q != 2'd0) begin
            IRQ_ADDR = VEC_BASE + VEC_STRIDE * {2'b00, num_q};
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: each stimulus step queues the outputs expected after
// the next clock edge, and the queue is drained against the DUT one cycle later.
module tb_irq_controller;

    logic       CLOCK_50;
    logic       KEY;
    logic [2:0] INT_IN;
    logic [2:0] INT_MASK;
    logic       IRQ_ACK;
    logic       IRQ_DONE;
    logic       IRQ_REQ;
    logic [1:0] IRQ_NUM;
    logic [3:0] IRQ_ADDR;
    logic [2:0] IRQ_PENDING;
    logic       IRQ_ACTIVE;

    typedef struct {
        string      tag;
        logic       req;
        logic [1:0] num;
        logic [3:0] addr;
        logic [2:0] pend;
        logic       act;
    } expect_t;

    expect_t sbQ[$];
    int checks   = 0;
    int failures = 0;

    irq_controller dut (
        .CLOCK_50   (CLOCK_50),
        .KEY        (KEY),
        .INT_IN     (INT_IN),
        .INT_MASK   (INT_MASK),
        .IRQ_ACK    (IRQ_ACK),
        .IRQ_DONE   (IRQ_DONE),
        .IRQ_REQ    (IRQ_REQ),
        .IRQ_NUM    (IRQ_NUM),
        .IRQ_ADDR   (IRQ_ADDR),
        .IRQ_PENDING(IRQ_PENDING),
        .IRQ_ACTIVE (IRQ_ACTIVE)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic pushExpect(input string tag, input logic req, input logic [1:0] num,
                              input logic [3:0] addr, input logic [2:0] pend, input logic act);
        expect_t e;
        e.tag  = tag;
        e.req  = req;
        e.num  = num;
        e.addr = addr;
        e.pend = pend;
        e.act  = act;
        sbQ.push_back(e);
    endtask

    task automatic scoreOutput();
        expect_t e;
        if (sbQ.size() == 0) begin
            checkOutput("sbEmpty", 8'(sbQ.size()), 8'd1);
        end else begin
            e = sbQ.pop_front();
            checkOutput({e.tag, ".req"},  8'(IRQ_REQ),     8'(e.req));
            checkOutput({e.tag, ".num"},  8'(IRQ_NUM),     8'(e.num));
            checkOutput({e.tag, ".addr"}, 8'(IRQ_ADDR),    8'(e.addr));
            checkOutput({e.tag, ".pend"}, 8'(IRQ_PENDING), 8'(e.pend));
            checkOutput({e.tag, ".act"},  8'(IRQ_ACTIVE),  8'(e.act));
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the coming edge, then score.
    task automatic applyStimulus(input string tag, input logic [2:0] intIn, input logic [2:0] mask,
                                 input logic ack, input logic done,
                                 input logic req, input logic [1:0] num, input logic [3:0] addr,
                                 input logic [2:0] pend, input logic act);
        INT_IN   = intIn;
        INT_MASK = mask;
        IRQ_ACK  = ack;
        IRQ_DONE = done;
        pushExpect(tag, req, num, addr, pend, act);
        tick();
        IRQ_ACK  = 1'b0;
        IRQ_DONE = 1'b0;
        scoreOutput();
    endtask

    initial begin
        KEY      = 1'b1;
        INT_IN   = 3'b000;
        INT_MASK = 3'b111;
        IRQ_ACK  = 1'b0;
        IRQ_DONE = 1'b0;
        #1 KEY = 1'b0;
        #1;
        pushExpect("reset", 1'b0, 2'd0, 4'h0, 3'b000, 1'b0);
        scoreOutput();
        idleCycles(2);
        KEY = 1'b1;
        idleCycles(5);

        // Single line, ignored ack/done, re-trigger during service, back-to-back re-request
        applyStimulus("ackIdle",   3'b000, 3'b111, 1, 0,  0, 2'd0, 4'h0, 3'b000, 0);
        applyStimulus("l1e1",      3'b010, 3'b111, 0, 0,  0, 2'd0, 4'h0, 3'b000, 0);
        applyStimulus("l1e2",      3'b010, 3'b111, 0, 0,  0, 2'd0, 4'h0, 3'b000, 0);
        applyStimulus("l1e3",      3'b010, 3'b111, 0, 0,  0, 2'd0, 4'h0, 3'b010, 0);
        applyStimulus("l1e4",      3'b010, 3'b111, 0, 0,  1, 2'd2, 4'h6, 3'b010, 0);
        applyStimulus("doneInReq", 3'b000, 3'b111, 0, 1,  1, 2'd2, 4'h6, 3'b010, 0);
        applyStimulus("ackToSvc",  3'b000, 3'b000, 1, 0,  0, 2'd2, 4'h6, 3'b000, 1);
        INT_MASK = 3'b111;
        idleCycles(2);
        applyStimulus("svcE1",     3'b010, 3'b111, 0, 0,  0, 2'd2, 4'h6, 3'b000, 1);
        applyStimulus("svcE2",     3'b010, 3'b111, 0, 0,  0, 2'd2, 4'h6, 3'b000, 1);
        applyStimulus("svcPend",   3'b010, 3'b111, 0, 0,  0, 2'd2, 4'h6, 3'b010, 1);
        applyStimulus("svcDone",   3'b010, 3'b111, 0, 1,  0, 2'd0, 4'h0, 3'b010, 0);
        applyStimulus("reReq",     3'b010, 3'b111, 0, 0,  1, 2'd2, 4'h6, 3'b010, 0);
        applyStimulus("reAck",     3'b010, 3'b111, 1, 0,  0, 2'd2, 4'h6, 3'b000, 1);
        applyStimulus("reDone",    3'b010, 3'b111, 0, 1,  0, 2'd0, 4'h0, 3'b000, 0);
        applyStimulus("levelHeld", 3'b010, 3'b111, 0, 0,  0, 2'd0, 4'h0, 3'b000, 0);
        INT_IN = 3'b000;
        idleCycles(4);

        // Simultaneous lines 0 and 2, ack+done together, back-to-back service
        INT_IN = 3'b101;
        idleCycles(2);
        applyStimulus("dualPend",  3'b101, 3'b111, 0, 0,  0, 2'd0, 4'h0, 3'b101, 0);
        applyStimulus("dualReq",   3'b101, 3'b111, 0, 0,  1, 2'd1, 4'h5, 3'b101, 0);
        applyStimulus("ackDone",   3'b101, 3'b111, 1, 1,  0, 2'd1, 4'h5, 3'b100, 1);
        applyStimulus("dualDone",  3'b101, 3'b111, 0, 1,  0, 2'd0, 4'h0, 3'b100, 0);
        applyStimulus("b2bReq",    3'b101, 3'b111, 0, 0,  1, 2'd3, 4'h7, 3'b100, 0);
        applyStimulus("b2bAck",    3'b101, 3'b111, 1, 0,  0, 2'd3, 4'h7, 3'b000, 1);
        applyStimulus("b2bDone",   3'b101, 3'b111, 0, 1,  0, 2'd0, 4'h0, 3'b000, 0);
        INT_IN = 3'b000;
        idleCycles(4);

        // Masked pending, unmask, then set-and-clear of the same bit on one edge
        INT_MASK = 3'b000;
        INT_IN   = 3'b100;
        idleCycles(2);
        applyStimulus("maskPend",  3'b100, 3'b000, 0, 0,  0, 2'd0, 4'h0, 3'b100, 0);
        applyStimulus("masked",    3'b100, 3'b000, 0, 0,  0, 2'd0, 4'h0, 3'b100, 0);
        applyStimulus("unmask",    3'b100, 3'b100, 0, 0,  1, 2'd3, 4'h7, 3'b100, 0);
        INT_IN = 3'b000;
        idleCycles(3);
        INT_IN = 3'b100;
        idleCycles(2);
        applyStimulus("setWins",   3'b100, 3'b100, 1, 0,  0, 2'd3, 4'h7, 3'b100, 1);
        applyStimulus("swDone",    3'b100, 3'b100, 0, 1,  0, 2'd0, 4'h0, 3'b100, 0);
        applyStimulus("swReq",     3'b100, 3'b100, 0, 0,  1, 2'd3, 4'h7, 3'b100, 0);
        applyStimulus("swAck",     3'b100, 3'b100, 1, 0,  0, 2'd3, 4'h7, 3'b000, 1);
        applyStimulus("swEnd",     3'b100, 3'b100, 0, 1,  0, 2'd0, 4'h0, 3'b000, 0);
        INT_IN   = 3'b000;
        INT_MASK = 3'b111;
        idleCycles(4);

        // Reset mid-request with the line held high through release
        INT_IN = 3'b001;
        idleCycles(3);
        applyStimulus("preRst",    3'b001, 3'b111, 0, 0,  1, 2'd1, 4'h5, 3'b001, 0);
        #2 KEY = 1'b0;
        #1;
        pushExpect("rstAsync", 1'b0, 2'd0, 4'h0, 3'b000, 1'b0);
        scoreOutput();
        idleCycles(2);
        KEY = 1'b1;
        idleCycles(8);
        pushExpect("noReqAfterRst", 1'b0, 2'd0, 4'h0, 3'b000, 1'b0);
        scoreOutput();
        INT_IN = 3'b000;
        idleCycles(2);

        if (sbQ.size() != 0) begin
            checkOutput("sbLeftover", 8'(sbQ.size()), 8'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
